// File: rtl/instr_loader.sv
// instr_loader: loads a checksummed byte-stream program image into instruction RAM, then starts the core.
// Ports:
//   CLK, Reset                  clock, async active-high reset
//   InByte, InValid, InReady    byte stream input with ready/valid handshake
//   WrEn, WrAddr, WrData        instruction memory write port (one-cycle strobe)
//   Start, Start_Addr           fetch-stage start request and entry address
//   Done                        core finished (sampled only in RUN)
//   Busy, Error, ClearErr       status and error acknowledge
module instr_loader #(
  parameter int ADDR_W       = 8,
  parameter int INSTR_W      = 9,
  parameter int START_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [7:0]         InByte,
  input  logic               InValid,
  output logic               InReady,
  output logic               WrEn,
  output logic [ADDR_W-1:0]  WrAddr,
  output logic [INSTR_W-1:0] WrData,
  output logic               Start,
  output logic [ADDR_W-1:0]  Start_Addr,
  input  logic               Done,
  output logic               Busy,
  output logic               Error,
  input  logic               ClearErr
);
  localparam int CW = $clog2(START_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, GET_COUNT, GET_LO, GET_HI, GET_CSUM, START, RUN, ERROR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d, wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic [7:0]         count_q, count_d, idx_q, idx_d, csum_q, csum_d, lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_en_q, wr_en_d;
  logic               fire;
  assign InReady    = state_q inside {IDLE, GET_COUNT, GET_LO, GET_HI, GET_CSUM};
  assign fire       = InValid && InReady;
  assign Busy       = state_q != IDLE;
  assign Error      = state_q == ERROR;
  assign Start      = state_q == START;
  assign Start_Addr = base_q;
  assign WrEn       = wr_en_q;
  assign WrAddr     = wr_addr_q;
  assign WrData     = wr_data_q;
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    idx_d     = idx_q;
    csum_d    = csum_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: if (fire) begin
        base_d  = ADDR_W'(InByte);
        csum_d  = InByte;
        state_d = GET_COUNT;
      end
      GET_COUNT: if (fire) begin
        count_d = InByte;
        idx_d   = 8'd0;
        csum_d  = csum_q ^ InByte;
        state_d = GET_LO;
      end
      GET_LO: if (fire) begin
        lo_d    = InByte;
        csum_d  = csum_q ^ InByte;
        state_d = GET_HI;
      end
      GET_HI: if (fire) begin
        if (InByte[7:1] != 7'd0) state_d = ERROR;
        else begin
          csum_d    = csum_q ^ InByte;
          wr_en_d   = 1'b1;
          wr_data_d = INSTR_W'({InByte[0], lo_q});
          wr_addr_d = base_q + ADDR_W'(idx_q);
          idx_d     = idx_q + 8'd1;
          // count of 0 wraps to 255 here, giving a 256-instruction image
          state_d   = (idx_q == count_q - 8'd1) ? GET_CSUM : GET_LO;
        end
      end
      GET_CSUM: if (fire) begin
        cnt_d   = '0;
        state_d = (InByte == csum_q) ? START : ERROR;
      end
      START: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(START_CYCLES - 1)) ? RUN : START;
      end
      RUN:     state_d = Done ? IDLE : RUN;
      ERROR:   state_d = ClearErr ? IDLE : ERROR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      csum_q    <= csum_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed scoreboard bench for instr_loader.
module tb_instr_loader;
  logic       CLK = 1'b0, Reset = 1'b0, InValid = 1'b0, Done = 1'b0, ClearErr = 1'b0;
  logic [7:0] InByte = 8'h00;
  logic       InReady, WrEn, Start, Busy, Error;
  logic [7:0] WrAddr, Start_Addr;
  logic [8:0] WrData;
  int compared = 0, mismatched = 0;
  logic [16:0] exp_q[$];
  instr_loader dut (
    .CLK(CLK), .Reset(Reset), .InByte(InByte), .InValid(InValid), .InReady(InReady),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Start(Start), .Start_Addr(Start_Addr),
    .Done(Done), .Busy(Busy), .Error(Error), .ClearErr(ClearErr)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge CLK) if (WrEn === 1'b1)
    chk("write", {15'd0, WrAddr, WrData}, (exp_q.size() != 0) ? {15'd0, exp_q.pop_front()} : 32'hDEAD_BEEF);
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    InValid = 1'b1;
    InByte  = b;
    while (InReady !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(n), 32'd0);
    tick();
  endtask
  task automatic send_stream(input logic [7:0] s[], input bit gaps);
    foreach (s[i]) begin
      if (gaps) begin
        InValid = 1'b0;
        tick();
      end
      send(s[i]);
    end
    InValid = 1'b0;
  endtask
  task automatic check_start(input logic [7:0] addr);
    chk("start_1", Start, 1'b1);
    chk("start_addr", Start_Addr, addr);
    tick();
    chk("start_2", Start, 1'b1);
    tick();
    chk("start_off", Start, 1'b0);
    chk("run_busy", Busy, 1'b1);
    chk("run_ready", InReady, 1'b0);
    chk("start_addr_run", Start_Addr, addr);
  endtask
  task automatic finish_run();
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("idle_busy", Busy, 1'b0);
    chk("idle_ready", InReady, 1'b1);
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
  endtask
  task automatic clear_err();
    ClearErr = 1'b1;
    tick();
    ClearErr = 1'b0;
    chk("clr_error", Error, 1'b0);
    chk("clr_ready", InReady, 1'b1);
    chk("clr_busy", Busy, 1'b0);
  endtask
  initial begin
    logic [7:0] s1[] = '{8'h10, 8'h02, 8'h34, 8'h01, 8'hA5, 8'h00, 8'h82};
    logic [7:0] s2[] = '{8'h10, 8'h02, 8'h34, 8'h01, 8'hA5, 8'h00, 8'h83};
    logic [7:0] s3[] = '{8'h00, 8'h01, 8'h55, 8'h02};
    logic [7:0] s4[] = '{8'hFF, 8'h02, 8'h11, 8'h00, 8'h22, 8'h01, 8'hCF};
    logic [7:0] s6[] = '{8'h10, 8'h02};
    #2 Reset = 1'b1;
    #1;
    chk("rst_ready", InReady, 1'b1);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_wren", WrEn, 1'b0);
    chk("rst_start", Start, 1'b0);
    chk("rst_error", Error, 1'b0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    // basic load
    exp_q.push_back({8'h10, 9'h134});
    exp_q.push_back({8'h11, 9'h0A5});
    send_stream(s1, 1'b0);
    check_start(8'h10);
    finish_run();
    // bad checksum
    exp_q.push_back({8'h10, 9'h134});
    exp_q.push_back({8'h11, 9'h0A5});
    send_stream(s2, 1'b0);
    chk("badcs_error", Error, 1'b1);
    chk("badcs_start", Start, 1'b0);
    chk("badcs_ready", InReady, 1'b0);
    tick();
    tick();
    chk("badcs_hold", Error, 1'b1);
    chk("badcs_nostart", Start, 1'b0);
    chk("badcs_drained", 32'(exp_q.size()), 32'd0);
    clear_err();
    // malformed HI
    send_stream(s3, 1'b0);
    chk("badhi_error", Error, 1'b1);
    chk("badhi_wren", WrEn, 1'b0);
    tick();
    clear_err();
    // address wrap
    exp_q.push_back({8'hFF, 9'h011});
    exp_q.push_back({8'h00, 9'h122});
    send_stream(s4, 1'b0);
    check_start(8'hFF);
    finish_run();
    // gaps plus bytes offered during START/RUN
    exp_q.push_back({8'h10, 9'h134});
    exp_q.push_back({8'h11, 9'h0A5});
    send_stream(s1, 1'b1);
    InValid = 1'b1;
    InByte  = 8'h77;
    check_start(8'h10);
    tick();
    chk("run_ignores_bytes", Busy, 1'b1);
    InValid = 1'b0;
    finish_run();
    // reset mid-load
    send_stream(s6, 1'b0);
    chk("mid_busy", Busy, 1'b1);
    Reset = 1'b1;
    #1;
    chk("arst_busy", Busy, 1'b0);
    chk("arst_ready", InReady, 1'b1);
    chk("arst_wraddr", WrAddr, 8'h00);
    chk("arst_wrdata", WrData, 9'h000);
    chk("arst_staddr", Start_Addr, 8'h00);
    tick();
    Reset = 1'b0;
    tick();
    exp_q.push_back({8'h10, 9'h134});
    exp_q.push_back({8'h11, 9'h0A5});
    send_stream(s1, 1'b0);
    check_start(8'h10);
    finish_run();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
